// File: rtl/cp0_unit_pkg.sv
// Shared constants for the CP0 unit: register numbers, exception codes and
// decoder op encodings.
package cp0_unit_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;

  typedef enum logic [1:0] {
    WT_NONE = 2'b00,
    WT_MTC0 = 2'b01,
    WT_MFC0 = 2'b10,
    WT_ERET = 2'b11
  } wt_op_e;

endpackage

// File: rtl/cp0_unit_if.sv
// Decoder <-> CP0 connection: instruction context and op code in, exception
// request, EPC and read data out. Interrupt lines travel with the bundle.
interface cp0_unit_if;
  logic [31:0] PC;
  logic [4:0]  Sel;
  logic [31:0] DIn;
  logic [1:0]  WT_PR;
  logic        OP_EXP;
  logic [5:0]  HWInt;
  logic        INT_REQ;
  logic [31:0] EPC_Out;
  logic [31:0] DOut;

  modport master (
    output PC, Sel, DIn, WT_PR, OP_EXP, HWInt,
    input  INT_REQ, EPC_Out, DOut
  );

  modport slave (
    input  PC, Sel, DIn, WT_PR, OP_EXP, HWInt,
    output INT_REQ, EPC_Out, DOut
  );
endinterface

// File: rtl/cp0_unit.sv
// CP0 unit: SR / Cause / EPC state, PRId constant, combinational exception
// request and mfc0 read mux, with reset > exception > eret > mtc0 priority.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h4D495053
) (
  input  logic       clk,
  input  logic       reset,
  cp0_unit_if.slave  bus
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_pend;
  logic        int_req;
  logic [31:0] dout;
  logic        unused_bits;

  // Exception request from registered SR and live interrupt / RI inputs
  always_comb begin
    int_pend = (|(bus.HWInt & im)) & ie & ~exl;
    int_req  = int_pend | (bus.OP_EXP & ~exl);
  end

  // Register state update: reset, then exception entry, eret, mtc0
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= bus.HWInt;
      if (int_req) begin
        epc      <= {bus.PC[31:2], 2'b00};
        exl      <= 1'b1;
        exc_code <= int_pend ? EXC_INT : EXC_RI;
      end else if (bus.WT_PR == WT_ERET) begin
        exl <= 1'b0;
      end else if (bus.WT_PR == WT_MTC0) begin
        if (bus.Sel == REG_SR) begin
          im  <= bus.DIn[15:10];
          exl <= bus.DIn[1];
          ie  <= bus.DIn[0];
        end else if (bus.Sel == REG_EPC) begin
          epc <= {bus.DIn[31:2], 2'b00};
        end
      end
    end
  end

  // mfc0 read mux; unimplemented register numbers read as zero
  always_comb begin
    dout = '0;
    case (bus.Sel)
      REG_SR:    dout = {16'b0, im, 8'b0, exl, ie};
      REG_CAUSE: dout = {16'b0, ip, 3'b0, exc_code, 2'b00};
      REG_EPC:   dout = epc;
      REG_PRID:  dout = PRID_VAL;
      default:   dout = '0;
    endcase
  end

  assign bus.INT_REQ = int_req;
  assign bus.EPC_Out = epc;
  assign bus.DOut    = dout;

  // Bits of the write data and PC that no register field holds
  assign unused_bits = ^{bus.DIn[31:16], bus.DIn[9:2], bus.PC[1:0]};

endmodule
